pc_stack: RTL
=============

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 12, entry width matching the program-counter width.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-005 SHALL have port push  input  1  push din onto the stack this cycle.
REQ-006 SHALL have port pop  input  1  remove the top entry this cycle.
REQ-007 SHALL have port din  input  WIDTH  return address to push.
REQ-008 SHALL have port clear_err  input  1  clears the sticky error flags.
REQ-009 SHALL have port dout  output  WIDTH  registered top-of-stack value.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-011 SHALL have port empty  output  1  high when count==0.
REQ-012 SHALL have port full  output  1  high when count==DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky; push attempted while full.
REQ-014 SHALL have port underflow  output  1  sticky; pop attempted while empty.

Function
REQ-015 SHALL perform push-only (push=1, pop=0, not full): store din as new top, count+1, dout=din after the same edge.
REQ-016 SHALL perform pop-only (pop=1, push=0, not empty): discard top, count-1, dout=new top after the edge, or 0 if the stack becomes empty.
REQ-017 SHALL treat push=1 and pop=1 with stack not empty as replace: top overwritten with din, count unchanged, dout=din after the edge.
REQ-018 SHALL treat push=1 and pop=1 with stack empty as push-only and set underflow.
REQ-019 SHALL ignore pop when empty: no state change other than underflow set; dout stays 0.
REQ-020 SHALL handle push when full per Configuration; overflow set in every case.
REQ-021 SHALL treat a replace (REQ-017) on a full stack as legal, with no overflow.
REQ-022 SHALL keep dout, count, empty and full consistent with each other after every edge; no combinational path from push/pop/din to any output.
REQ-023 SHALL hold all state when push=0 and pop=0.
REQ-024 SHALL clear overflow and underflow on clear_err=1; an error event in the same cycle wins, leaving the flag set.
REQ-025 SHALL keep the count arithmetic exact with no wrap: count never exceeds DEPTH and never goes below 0.

Reset
REQ-026 SHALL, on rst=1 at posedge clk, set count=0, dout=0, empty=1, full=0, overflow=0, underflow=0.
REQ-027 SHALL let rst override push, pop and clear_err in the same cycle.
REQ-028 SHALL not clear stored entry contents on reset; after reset they are unreachable until rewritten.
REQ-029 SHALL abandon any in-progress stack contents when reset is asserted mid-operation; the first post-reset pop SHALL underflow.

Configuration
REQ-030 SHALL use macro PC_STACK_WRAP_EN to select full-stack push behaviour.
REQ-031 SHALL, with PC_STACK_WRAP_EN defined, implement storage as a circular buffer: push when full overwrites the oldest entry, din becomes top, count stays DEPTH, overflow set.
REQ-032 SHALL, without PC_STACK_WRAP_EN, drop a push when full: contents, dout and count unchanged, overflow set.

Verification
REQ-033 SHALL cover reset then push 0x123, 0x456, 0x789 -> dout=0x789, count=3; three pops -> dout 0x456, 0x123, 0, empty=1.
REQ-034 SHALL cover pop on an empty stack -> underflow=1, count=0, dout=0; clear_err=1 one cycle -> underflow=0.
REQ-035 SHALL cover pushing 0x001..0x008 (DEPTH=8) then pushing 0x009 -> full=1, overflow=1. Without the macro: dout=0x008, and 8 pops return 0x008..0x001. With the macro: dout=0x009, and 8 pops return 0x009..0x002.
REQ-036 SHALL cover push 0x0AA, then push=pop=1 with din=0x0BB -> dout=0x0BB, count=1, no error flags.
REQ-037 SHALL cover rst=1 asserted with push=1 after 3 pushes -> next cycle count=0, dout=0, empty=1, flags=0.
REQ-038 SHALL cover clear_err=1 concurrent with pop on empty -> underflow=1 after the edge.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: hardware return-address stack for a program counter.
// The storage is a DEPTH-entry ring addressed by a top-of-stack pointer.
// Push, pop and replace (push+pop) are supported, and dout is registered.
// Sticky overflow/underflow flags are cleared by clear_err; an error event
// in the same cycle wins over the clear.
// Optional macro PC_STACK_WRAP_EN: when it is defined, a push on a full stack
// overwrites the oldest entry. When it is undefined, that push is dropped.
// Overflow is flagged in both cases.
module pc_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_top;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic             w_do_replace;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [AW-1:0]    w_top_inc;
  logic [AW-1:0]    w_top_dec;
  logic [AW-1:0]    w_wr_idx;

  // Decode the requested operation from the current occupancy.
  always_comb begin
    w_empty      = (r_count == '0);
    w_full       = (r_count == FULL_CNT);
    w_top_inc    = r_top + 1'b1;
    w_top_dec    = r_top - 1'b1;
    w_do_replace = push & pop & ~w_empty;
    // A push that is not a replace; on an empty stack a concurrent pop is ignored.
`ifdef PC_STACK_WRAP_EN
    // The ring pointer advances onto the oldest slot when full, overwriting it.
    w_do_push    = push & ~w_do_replace;
`else
    w_do_push    = push & ~w_do_replace & ~w_full;
`endif
    w_do_pop     = pop & ~push & ~w_empty;
    w_ovf_evt    = push & ~w_do_replace & w_full;
    w_unf_evt    = pop & w_empty;
    w_wr_idx     = w_do_push ? w_top_inc : r_top;
  end

  // Entry storage; contents deliberately survive reset and become unreachable.
  always_ff @(posedge clk) begin
    if (!rst && (w_do_push || w_do_replace))
      r_mem[w_wr_idx] <= din;
  end

  // Pointer, count, registered top-of-stack and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_top   <= '1;
      r_count <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_top  <= w_top_inc;
        r_dout <= din;
        if (!w_full)
          r_count <= r_count + 1'b1;
      end else if (w_do_replace) begin
        r_dout <= din;
      end else if (w_do_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - 1'b1;
        r_dout  <= (r_count == ONE_CNT) ? '0 : r_mem[w_top_dec];
      end
      r_ovf <= (r_ovf & ~clear_err) | w_ovf_evt;
      r_unf <= (r_unf & ~clear_err) | w_unf_evt;
    end
  end

  // Status outputs derive only from registered state.
  always_comb begin
    dout      = r_dout;
    count     = r_count;
    empty     = (r_count == '0);
    full      = (r_count == FULL_CNT);
    overflow  = r_ovf;
    underflow = r_unf;
  end

endmodule
